// File: rtl/fb_rect_writer_if.sv
// Rectangle command, pixel stream and SDRAM write-FIFO port bundle
// for the framebuffer rectangle writer.
interface fb_rect_writer_if #(
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 21
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_x;
  logic [15:0]       cmd_y;
  logic [15:0]       cmd_w;
  logic [15:0]       cmd_h;
  logic              cmd_mode;
  logic [PIX_W-1:0]  cmd_color;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              mem_ready;
  logic              wr_load;
  logic [ADDR_W-1:0] wr_min_addr;
  logic [ADDR_W-1:0] wr_max_addr;
  logic              wr_en;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h,
    output cmd_mode, cmd_color,
    output pix_valid, pix_data, mem_ready,
    input  cmd_ready, pix_ready,
    input  wr_load, wr_min_addr, wr_max_addr,
    input  wr_en, wr_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h,
    input  cmd_mode, cmd_color,
    input  pix_valid, pix_data, mem_ready,
    output cmd_ready, pix_ready,
    output wr_load, wr_min_addr, wr_max_addr,
    output wr_en, wr_data, busy, done, err
  );
endinterface

// File: rtl/fb_rect_writer.sv
// Writes a clipped rectangle (solid fill or streamed pixels) into the
// framebuffer through the SDRAM write-FIFO, one row per FIFO load.
module fb_rect_writer #(
  parameter int H_DISP    = 1024,
  parameter int V_DISP    = 600,
  parameter int PIX_W     = 24,
  parameter int ADDR_W    = 21,
  parameter int WE_DIV    = 2,
  parameter int FLUSH_CYC = 16
) (
  input logic            clk,
  input logic            rst_n,
  fb_rect_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    FLUSH
  } state_t;

  localparam logic [31:0] HD = 32'(H_DISP);
  localparam logic [31:0] VD = 32'(V_DISP);
  localparam logic [15:0] DIV_LAST = 16'(WE_DIV - 1);
  localparam logic [15:0] FL_LAST  = 16'(FLUSH_CYC - 1);

  state_t st, nx;

  logic              mode;
  logic [PIX_W-1:0]  color;
  logic [15:0]       clip_w;
  logic [15:0]       rows_left;
  logic [15:0]       col_cnt;
  logic [15:0]       div_cnt;
  logic [15:0]       flush_cnt;
  logic [ADDR_W-1:0] row_addr;
  logic              err_q;
  logic              done_q;

  logic [31:0]       x32, y32, w32, h32;
  logic [31:0]       room_w, room_h;
  logic [15:0]       cw, ch;
  logic [ADDR_W-1:0] base;
  logic              bad, accept, abort;
  logic              slot, last_pix, last_row;
  logic              wr_en, wr_load;

  assign x32 = 32'(bus.cmd_x);
  assign y32 = 32'(bus.cmd_y);
  assign w32 = 32'(bus.cmd_w);
  assign h32 = 32'(bus.cmd_h);

  assign bad = (x32 >= HD) || (y32 >= VD) ||
               (w32 == 32'd0) || (h32 == 32'd0);

  // room_* only meaningful when the origin is on screen
  assign room_w = HD - x32;
  assign room_h = VD - y32;
  assign cw = (w32 < room_w) ? bus.cmd_w : 16'(room_w);
  assign ch = (h32 < room_h) ? bus.cmd_h : 16'(room_h);
  assign base = ADDR_W'(y32 * HD + x32);

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign abort  = (st != IDLE) && !bus.mem_ready;

  assign slot = (st == WRITE) && (div_cnt == DIV_LAST) &&
                bus.mem_ready;
  assign wr_en   = slot && (!mode || bus.pix_valid);
  assign wr_load = (st == LOAD) && bus.mem_ready;

  assign last_pix = (col_cnt == clip_w - 16'd1);
  assign last_row = (rows_left == 16'd1);

  assign bus.cmd_ready = rst_n && (st == IDLE) && bus.mem_ready;
  assign bus.busy      = (st != IDLE);
  assign bus.pix_ready = slot && mode;
  assign bus.wr_en     = wr_en;
  assign bus.wr_load   = wr_load;
  assign bus.wr_data   = !wr_en ? '0 :
                         mode ? bus.pix_data : color;
  assign bus.wr_min_addr = wr_load ? row_addr : '0;
  assign bus.wr_max_addr = wr_load ?
                           row_addr + ADDR_W'(clip_w) : '0;
  assign bus.done = done_q;
  assign bus.err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (1'b1)
      (st == IDLE):
        if (accept && !bad) nx = LOAD;
      (st == LOAD):
        nx = WRITE;
      (st == WRITE):
        if (wr_en && last_pix) nx = FLUSH;
      (st == FLUSH):
        if (flush_cnt == FL_LAST)
          nx = last_row ? IDLE : LOAD;
      default:
        nx = IDLE;
    endcase
    if (abort) nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= 1'b0;
      color     <= '0;
      clip_w    <= '0;
      rows_left <= '0;
      col_cnt   <= '0;
      div_cnt   <= '0;
      flush_cnt <= '0;
      row_addr  <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      err_q  <= (accept && bad) || abort;
      done_q <= (st == FLUSH) && (nx == IDLE) && !abort;
      if (accept && !bad) begin
        mode      <= bus.cmd_mode;
        color     <= bus.cmd_color;
        clip_w    <= cw;
        rows_left <= ch;
        row_addr  <= base;
      end
      if (st == LOAD) begin
        div_cnt <= '0;
        col_cnt <= '0;
      end
      if (st == WRITE) begin
        div_cnt <= (div_cnt == DIV_LAST) ?
                   16'd0 : div_cnt + 16'd1;
        if (wr_en) col_cnt <= col_cnt + 16'd1;
        if (nx == FLUSH) flush_cnt <= '0;
      end
      if (st == FLUSH) begin
        flush_cnt <= flush_cnt + 16'd1;
        if (flush_cnt == FL_LAST) begin
          row_addr  <= row_addr + ADDR_W'(H_DISP);
          rows_left <= rows_left - 16'd1;
        end
      end
    end
  end

endmodule
